// File: rtl/mips_mem_stage.sv
// Memory stage of the multicycle MIPS core: unified instruction/data memory with wait states, IR and MDR.
// Optional access trace is enabled by defining MEM_TRACE_EN.

module mips_mem_stage #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_start,
    input  logic        IorD,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic        byte_mode,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] mdr,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        toIr_q, toIr_d;
    logic        byte_q, byte_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mdr_q, mdr_d;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  misaligned;
    logic [31:0]           rdWord;
    logic [7:0]            rdByte;
    logic [31:0]           rdVal;
    logic                  unused_addrHigh;

    // Upper address bits are dropped, so accesses wrap modulo the array size.
    assign idx             = addr_q[ADDR_WIDTH+1:2];
    assign misaligned      = !byte_q && (addr_q[1:0] != 2'b00);
    assign rdWord          = mem[idx];
    assign unused_addrHigh = ^addr_q[31:ADDR_WIDTH+2];

    // Big-endian lane select with sign extension for LB.
    always_comb begin
        rdByte = rdWord[7:0];
        case (addr_q[1:0])
            2'd0:    rdByte = rdWord[31:24];
            2'd1:    rdByte = rdWord[23:16];
            2'd2:    rdByte = rdWord[15:8];
            default: rdByte = rdWord[7:0];
        endcase
        rdVal = byte_q ? {{24{rdByte[7]}}, rdByte} : rdWord;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            toIr_q  <= 1'b0;
            byte_q  <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            toIr_q  <= toIr_d;
            byte_q  <= byte_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
        end
    end

    // Read data lands in IR/MDR on the ACCESS->DONE edge so it is visible alongside mem_ready.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        toIr_d    = toIr_q;
        byte_d    = byte_q;
        instr_d   = instr_q;
        mdr_d     = mdr_q;
        mem_ready = 1'b0;
        mem_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_start) begin
                    addr_d  = IorD ? alu_out : pc;
                    wdata_d = write_data;
                    wr_d    = MemWrite;
                    toIr_d  = IRWrite;
                    byte_d  = byte_mode;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (misaligned) begin
                    mem_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (!wr_q) begin
                        if (toIr_q) begin
                            instr_d = rdVal;
                        end else begin
                            mdr_d = rdVal;
                        end
                    end
                end
            end
            default: begin
                mem_ready = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // The array is not reset; a reset arriving in ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && state_q == ACCESS && wr_q && !misaligned) begin
            if (byte_q) begin
                case (addr_q[1:0])
                    2'd0:    mem[idx][31:24] <= wdata_q[7:0];
                    2'd1:    mem[idx][23:16] <= wdata_q[7:0];
                    2'd2:    mem[idx][15:8]  <= wdata_q[7:0];
                    default: mem[idx][7:0]   <= wdata_q[7:0];
                endcase
            end else begin
                mem[idx] <= wdata_q;
            end
        end
    end

`ifdef MEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && state_q == ACCESS && !misaligned) begin
            $display("[MEM] t=%0t %s %s addr=0x%08h data=0x%08h dest=%s", $time,
                     wr_q ? "W" : "R", byte_q ? "byte" : "word", addr_q,
                     wr_q ? wdata_q : rdVal, wr_q ? "MEM" : (toIr_q ? "IR" : "MDR"));
        end
    end
`else
    // Default build emits no simulation output.
`endif

    assign instr = instr_q;
    assign op    = instr_q[31:26];
    assign mdr   = mdr_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mips_mem_stage.sv
// Self-checking bench for mips_mem_stage: directed vector table, hand-written corner sequences,
// and randomized accesses checked against a word-array reference model (instances with 1 and 0 wait states).

module tb_mips_mem_stage;

    logic        clk;
    logic        reset;
    logic        startA, startB;
    logic        iord, memWrite, irWrite, byteMode;
    logic [31:0] pcIn, aluIn, wdIn;
    logic [31:0] instrA, mdrA, instrB, mdrB;
    logic [5:0]  opA, opB;
    logic        readyA, errA, busyA, readyB, errB, busyB;

    int checks = 0;
    int fails  = 0;

    mips_mem_stage #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) dutA (
        .clk(clk), .reset(reset), .mem_start(startA), .IorD(iord), .MemWrite(memWrite),
        .IRWrite(irWrite), .byte_mode(byteMode), .pc(pcIn), .alu_out(aluIn), .write_data(wdIn),
        .instr(instrA), .op(opA), .mdr(mdrA), .mem_ready(readyA), .mem_err(errA), .busy(busyA)
    );

    mips_mem_stage #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .reset(reset), .mem_start(startB), .IorD(iord), .MemWrite(memWrite),
        .IRWrite(irWrite), .byte_mode(byteMode), .pc(pcIn), .alu_out(aluIn), .write_data(wdIn),
        .instr(instrB), .op(opB), .mdr(mdrB), .mem_ready(readyB), .mem_err(errB), .busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        int          sel;
        bit          iord, wr, irw, bm;
        logic [31:0] pcv, alu, wd;
        bit          expErr;
        int          expLat;
        logic [31:0] expInstr, expMdr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain word arrays plus the architectural IR/MDR per instance.
    logic [31:0] modelMem [2][256];
    logic [31:0] mInstr [2];
    logic [31:0] mMdr [2];

    function automatic vec_t mkVec(int sel, bit iordV, bit wr, bit irw, bit bm,
                                   logic [31:0] pcv, logic [31:0] alu, logic [31:0] wd,
                                   bit expErr, int expLat, logic [31:0] expInstr, logic [31:0] expMdr);
        vec_t v;
        v.sel = sel; v.iord = iordV; v.wr = wr; v.irw = irw; v.bm = bm;
        v.pcv = pcv; v.alu = alu; v.wd = wd;
        v.expErr = expErr; v.expLat = expLat; v.expInstr = expInstr; v.expMdr = expMdr;
        return v;
    endfunction

    function automatic logic [31:0] instrOf(int sel);
        return (sel == 0) ? instrA : instrB;
    endfunction

    function automatic logic [31:0] mdrOf(int sel);
        return (sel == 0) ? mdrA : mdrB;
    endfunction

    function automatic logic [31:0] opOf(int sel);
        return (sel == 0) ? {26'b0, opA} : {26'b0, opB};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request, scrambles the inputs after accept, and waits (bounded) for the
    // completion or error pulse; returns at the sampling point of that pulse cycle.
    task automatic applyStimulus(input int sel, input bit iordV, input bit wr, input bit irw, input bit bm,
                                 input logic [31:0] pcv, input logic [31:0] alu, input logic [31:0] wd,
                                 input bit poke, output bit gotErr, output bit gotReady, output int lat);
        bit done;
        @(negedge clk);
        iord = iordV; memWrite = wr; irWrite = irw; byteMode = bm;
        pcIn = pcv; aluIn = alu; wdIn = wd;
        if (sel == 0) startA = 1'b1; else startB = 1'b1;
        @(negedge clk);
        startA = 1'b0; startB = 1'b0;
        iord = 1'($urandom); memWrite = 1'($urandom); irWrite = 1'($urandom); byteMode = 1'($urandom);
        pcIn = $urandom; aluIn = $urandom; wdIn = $urandom;
        if (poke) begin
            iord = 1'b1; memWrite = 1'b1; irWrite = 1'b0; byteMode = 1'b0;
            aluIn = 32'h0; wdIn = 32'hBAD0BAD0;
            if (sel == 0) startA = 1'b1; else startB = 1'b1;
        end
        lat = 1;
        done = 1'b0;
        gotErr = 1'b0;
        gotReady = 1'b0;
        while (!done) begin
            gotReady = (sel == 0) ? readyA : readyB;
            gotErr   = (sel == 0) ? errA : errB;
            if (gotReady || gotErr || lat >= 40) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                startA = 1'b0; startB = 1'b0;
                lat++;
            end
        end
    endtask

    task automatic modelAccess(input int sel, input logic [31:0] addr, input bit wr, input bit irw,
                               input bit bm, input logic [31:0] wd, output bit expErr);
        int unsigned wordIdx = (addr >> 2) % 256;
        int unsigned lane    = addr % 4;
        int unsigned shift   = 8 * (3 - lane);
        logic [31:0] word    = modelMem[sel][wordIdx];
        logic [31:0] mask    = 32'hFF << shift;
        logic [7:0]  b;
        logic [31:0] val;
        expErr = (!bm && lane != 0);
        if (expErr) return;
        if (wr) begin
            if (bm) modelMem[sel][wordIdx] = (word & ~mask) | ({24'b0, wd[7:0]} << shift);
            else    modelMem[sel][wordIdx] = wd;
        end else begin
            b   = 8'((word >> shift) & 32'hFF);
            val = bm ? {{24{b[7]}}, b} : word;
            if (irw) mInstr[sel] = val;
            else     mMdr[sel]   = val;
        end
    endtask

    task automatic runModelled(input int sel, input bit iordV, input bit wr, input bit irw, input bit bm,
                               input logic [31:0] pcv, input logic [31:0] alu, input logic [31:0] wd);
        bit expErr, gotErr, gotReady;
        int lat;
        int waits = (sel == 0) ? 1 : 0;
        modelAccess(sel, iordV ? alu : pcv, wr, irw, bm, wd, expErr);
        applyStimulus(sel, iordV, wr, irw, bm, pcv, alu, wd, 1'b0, gotErr, gotReady, lat);
        checkOutput("rndKind", {30'b0, gotErr, gotReady}, {30'b0, expErr, !expErr});
        checkOutput("rndLatency", lat, waits + (expErr ? 1 : 2));
        checkOutput("rndInstr", instrOf(sel), mInstr[sel]);
        checkOutput("rndMdr", mdrOf(sel), mMdr[sel]);
        checkOutput("rndOp", opOf(sel), {26'b0, mInstr[sel][31:26]});
    endtask

    initial begin
        bit gotErr, gotReady, anyActivity;
        int lat;

        reset = 1'b1; startA = 1'b0; startB = 1'b0;
        iord = 1'b0; memWrite = 1'b0; irWrite = 1'b0; byteMode = 1'b0;
        pcIn = '0; aluIn = '0; wdIn = '0;

        // Directed table: instance A has one wait state, instance B none.
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 32'h6,   32'h0,  32'h8C010004, 0, 3, 32'h0,        32'h0));
        vecs.push_back(mkVec(0, 0, 0, 1, 0, 32'h0,   32'h6,  32'h0,        0, 3, 32'h8C010004, 32'h0));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 32'h6,   32'h10, 32'hDEADBEEF, 0, 3, 32'h8C010004, 32'h0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h6,   32'h10, 32'h0,        0, 3, 32'h8C010004, 32'hDEADBEEF));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 32'h6,   32'h20, 32'h80FF1234, 0, 3, 32'h8C010004, 32'hDEADBEEF));
        vecs.push_back(mkVec(0, 1, 0, 0, 1, 32'h6,   32'h20, 32'h0,        0, 3, 32'h8C010004, 32'hFFFFFF80));
        vecs.push_back(mkVec(0, 1, 0, 0, 1, 32'h6,   32'h22, 32'h0,        0, 3, 32'h8C010004, 32'h00000012));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 32'h6,   32'h10, 32'h0,        0, 3, 32'h8C010004, 32'h00000012));
        vecs.push_back(mkVec(0, 1, 1, 0, 1, 32'h6,   32'h11, 32'h123456AB, 0, 3, 32'h8C010004, 32'h00000012));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h6,   32'h10, 32'h0,        0, 3, 32'h8C010004, 32'h00AB0000));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h6,   32'h6,  32'h0,        1, 2, 32'h8C010004, 32'h00AB0000));
        vecs.push_back(mkVec(0, 1, 1, 0, 0, 32'h6,   32'h2,  32'hFFFFFFFF, 1, 2, 32'h8C010004, 32'h00AB0000));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h6,   32'h0,  32'h0,        0, 3, 32'h8C010004, 32'h8C010004));
        vecs.push_back(mkVec(0, 1, 1, 1, 0, 32'h6,   32'h30, 32'h11223344, 0, 3, 32'h8C010004, 32'h8C010004));
        vecs.push_back(mkVec(0, 1, 0, 1, 0, 32'h6,   32'h30, 32'h0,        0, 3, 32'h11223344, 32'h8C010004));
        vecs.push_back(mkVec(0, 1, 0, 1, 1, 32'h6,   32'h33, 32'h0,        0, 3, 32'h00000044, 32'h8C010004));
        vecs.push_back(mkVec(0, 1, 0, 0, 1, 32'h6,   32'h31, 32'h0,        0, 3, 32'h00000044, 32'h00000022));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 32'h400, 32'h6,  32'h0,        0, 3, 32'h00000044, 32'h8C010004));
        vecs.push_back(mkVec(1, 1, 1, 0, 0, 32'h6,   32'h0,  32'h01234567, 0, 2, 32'h0,        32'h0));
        vecs.push_back(mkVec(1, 0, 0, 1, 0, 32'h400, 32'h5,  32'h0,        0, 2, 32'h01234567, 32'h0));
        vecs.push_back(mkVec(1, 1, 0, 0, 0, 32'h6,   32'h5,  32'h0,        1, 1, 32'h01234567, 32'h0));
        vecs.push_back(mkVec(1, 1, 0, 0, 1, 32'h6,   32'h403, 32'h0,       0, 2, 32'h01234567, 32'h00000067));

        repeat (3) @(negedge clk);
        checkOutput("resetInstrA", instrA, 32'h0);
        checkOutput("resetMdrA", mdrA, 32'h0);
        checkOutput("resetOpA", {26'b0, opA}, 32'h0);
        checkOutput("resetCtlA", {29'b0, readyA, errA, busyA}, 32'h0);
        checkOutput("resetCtlB", {29'b0, readyB, errB, busyB}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].iord, vecs[i].wr, vecs[i].irw, vecs[i].bm,
                          vecs[i].pcv, vecs[i].alu, vecs[i].wd, 1'b0, gotErr, gotReady, lat);
            checkOutput($sformatf("vec%0d_kind", i), {30'b0, gotErr, gotReady},
                        {30'b0, vecs[i].expErr, !vecs[i].expErr});
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("vec%0d_instr", i), instrOf(vecs[i].sel), vecs[i].expInstr);
            checkOutput($sformatf("vec%0d_mdr", i), mdrOf(vecs[i].sel), vecs[i].expMdr);
            checkOutput($sformatf("vec%0d_op", i), opOf(vecs[i].sel), {26'b0, vecs[i].expInstr[31:26]});
        end

        // A second mem_start while busy (a word-0 write) must be dropped entirely.
        applyStimulus(0, 1, 0, 0, 0, 32'h6, 32'h30, 32'h0, 1'b1, gotErr, gotReady, lat);
        checkOutput("overlapReady", {31'b0, gotReady}, 32'h1);
        checkOutput("overlapLatency", lat, 3);
        checkOutput("overlapMdr", mdrA, 32'h11223344);
        anyActivity = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (readyA || errA || busyA) anyActivity = 1'b1;
        end
        checkOutput("overlapIdle", {31'b0, anyActivity}, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h6, 32'h0, 32'h0, 1'b0, gotErr, gotReady, lat);
        checkOutput("overlapWord0", mdrA, 32'h8C010004);

        // Reset during WAIT of a write: aborted, nothing committed, IR/MDR cleared.
        @(negedge clk);
        iord = 1'b1; memWrite = 1'b1; irWrite = 1'b0; byteMode = 1'b0;
        aluIn = 32'h30; wdIn = 32'hCAFEF00D; startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("abortBusyInWait", {31'b0, busyA}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortBusyCleared", {31'b0, busyA}, 32'h0);
        checkOutput("abortInstr", instrA, 32'h0);
        checkOutput("abortMdr", mdrA, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h6, 32'h30, 32'h0, 1'b0, gotErr, gotReady, lat);
        checkOutput("abortNoWrite", mdrA, 32'h11223344);

        // Randomized phase: preload a 16-word window, then mixed accesses with wrapping addresses.
        for (int sel = 0; sel < 2; sel++) begin
            mInstr[sel] = 32'h0;
            mMdr[sel]   = (sel == 0) ? 32'h11223344 : 32'h0;
            for (int w = 0; w < 16; w++) begin
                runModelled(sel, 1, 1, 0, 0, $urandom, (32'(w) << 2) | ($urandom << 10), $urandom);
            end
            for (int n = 0; n < 60; n++) begin
                logic [31:0] addr, other;
                bit          iordV;
                addr  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)) | ($urandom << 10);
                other = $urandom;
                iordV = 1'($urandom);
                runModelled(sel, iordV, ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                            iordV ? other : addr, iordV ? addr : other, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
